// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues instruction fetches, applies branch/jump
// redirects, honours downstream stall and discards responses from stale fetches.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_add_4,
  input  logic        br_valid,
  input  logic        branch,
  input  logic        bne,
  input  logic        eqRes,
  input  logic [31:0] branch_pc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        stall,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;

  logic        taken;
  logic        redirect;
  logic [31:0] target;

  assign taken    = (bne & ~eqRes) | (branch & ~bne & eqRes);
  assign redirect = br_valid & (jump | taken);
  assign target   = jump ? {jump_addr[31:2], 2'b00} : {branch_pc[31:2], 2'b00};

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_add_4  = pc_q + 32'd4;
  assign flush     = flush_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
          // A redirect with the request still pending must wait out its response.
          state_d = imem_ready ? FETCH : DRAIN;
        end else if (imem_ready) begin
          instr_valid = 1'b1;
          pc_d        = pc_add_4;
          state_d     = stall ? STALL : FETCH;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
        end
        if (imem_ready) begin
          state_d = FETCH;
        end
      end

      STALL: begin
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
        end
        if (!stall) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, branch and
// jump redirects, drain of stale responses, stall handling, wrap and async reset.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_add_4;
  logic        br_valid;
  logic        branch;
  logic        bne;
  logic        eqRes;
  logic [31:0] branch_pc;
  logic        jump;
  logic [31:0] jump_addr;
  logic        stall;
  logic        flush;

  int unsigned tests_run;
  int unsigned tests_failed;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_add_4   (pc_add_4),
    .br_valid   (br_valid),
    .branch     (branch),
    .bne        (bne),
    .eqRes      (eqRes),
    .branch_pc  (branch_pc),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .stall      (stall),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_br;
    br_valid  = 1'b0;
    branch    = 1'b0;
    bne       = 1'b0;
    eqRes     = 1'b0;
    jump      = 1'b0;
    branch_pc = '0;
    jump_addr = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    imem_ready   = 1'b1;
    stall        = 1'b0;
    clear_br();

    // Reset state, with imem_ready already high
    tick();
    tick();
    chk("rst_req",   imem_req,    1'b0);
    chk("rst_pc",    pc,          32'h0);
    chk("rst_flush", flush,       1'b0);
    chk("rst_valid", instr_valid, 1'b0);

    // First cycle after release is IDLE, request in the second
    rst_n = 1'b1;
    #1;
    chk("idle_req", imem_req, 1'b0);
    tick();
    chk("f0_req",   imem_req,    1'b1);
    chk("f0_addr",  imem_addr,   32'h0);
    chk("f0_valid", instr_valid, 1'b1);
    tick();
    chk("f1_addr",  imem_addr,   32'h4);
    chk("f1_valid", instr_valid, 1'b1);
    tick();
    chk("f2_addr",  imem_addr,   32'h8);
    tick();
    chk("f3_addr",  imem_addr,   32'hC);
    chk("f3_valid", instr_valid, 1'b1);

    // Taken beq together with completion
    br_valid = 1'b1; branch = 1'b1; bne = 1'b0; eqRes = 1'b1; branch_pc = 32'h100;
    #1;
    chk("beq_valid", instr_valid, 1'b0);
    chk("beq_flush_pre", flush,   1'b0);
    tick();
    clear_br();
    #1;
    chk("beq_pc",    pc,          32'h100);
    chk("beq_flush", flush,       1'b1);
    chk("beq_valid_after", instr_valid, 1'b1);
    tick();
    chk("beq_pc2",   pc,    32'h104);
    chk("beq_flush_off", flush, 1'b0);

    // bne with equal operands: not taken
    br_valid = 1'b1; bne = 1'b1; eqRes = 1'b1; branch_pc = 32'h200;
    #1;
    chk("bne_nt_valid", instr_valid, 1'b1);
    tick();
    chk("bne_nt_pc",    pc,    32'h108);
    chk("bne_nt_flush", flush, 1'b0);

    // bne with unequal operands: taken
    eqRes = 1'b0;
    #1;
    chk("bne_t_valid", instr_valid, 1'b0);
    tick();
    chk("bne_t_pc",    pc,    32'h200);
    chk("bne_t_flush", flush, 1'b1);

    // Jump outranks a taken branch; low bits of target cleared
    br_valid = 1'b1; bne = 1'b0; branch = 1'b1; eqRes = 1'b1; branch_pc = 32'h500;
    jump = 1'b1; jump_addr = 32'h302;
    tick();
    clear_br();
    #1;
    chk("jmp_prio_pc", pc, 32'h300);

    // Redirect while request pending, second redirect in DRAIN
    imem_ready = 1'b0;
    br_valid = 1'b1; branch = 1'b1; eqRes = 1'b1; branch_pc = 32'h40;
    #1;
    chk("dr_req_pre", imem_req,    1'b1);
    chk("dr_val_pre", instr_valid, 1'b0);
    tick();
    chk("dr_pc1",    pc,        32'h40);
    chk("dr_flush1", flush,     1'b1);
    chk("dr_req1",   imem_req,  1'b1);
    chk("dr_addr1",  imem_addr, 32'h40);
    clear_br();
    br_valid = 1'b1; jump = 1'b1; jump_addr = 32'h80;
    tick();
    clear_br();
    #1;
    chk("dr_pc2",    pc,       32'h80);
    chk("dr_flush2", flush,    1'b1);
    tick();
    chk("dr_flush3", flush,    1'b0);
    chk("dr_req3",   imem_req, 1'b1);
    imem_ready = 1'b1;
    #1;
    chk("dr_discard", instr_valid, 1'b0);
    tick();
    chk("dr_resume_addr",  imem_addr,   32'h80);
    chk("dr_resume_valid", instr_valid, 1'b1);

    // Stall on completion, jump during stall
    stall = 1'b1;
    tick();
    chk("st_pc",    pc,          32'h84);
    chk("st_req",   imem_req,    1'b0);
    chk("st_valid", instr_valid, 1'b0);
    tick();
    chk("st_hold_pc", pc, 32'h84);
    br_valid = 1'b1; jump = 1'b1; jump_addr = 32'h1003;
    tick();
    clear_br();
    #1;
    chk("st_jmp_pc",    pc,       32'h1000);
    chk("st_jmp_flush", flush,    1'b1);
    chk("st_jmp_req",   imem_req, 1'b0);
    tick();
    chk("st_flush_off", flush,    1'b0);
    chk("st_pc_hold2",  pc,       32'h1000);
    stall = 1'b0;
    #1;
    chk("st_release_req", imem_req, 1'b0);
    tick();
    chk("st_resume_req",  imem_req,  1'b1);
    chk("st_resume_addr", imem_addr, 32'h1000);
    imem_ready = 1'b0;
    #1;
    chk("hold_valid", instr_valid, 1'b0);
    tick();
    chk("hold_pc",  pc,       32'h1000);
    chk("hold_req", imem_req, 1'b1);

    // Wrap at top of address space
    imem_ready = 1'b1;
    br_valid = 1'b1; jump = 1'b1; jump_addr = 32'hFFFF_FFFF;
    tick();
    clear_br();
    #1;
    chk("wrap_pc",   pc,       32'hFFFF_FFFC);
    chk("wrap_add4", pc_add_4, 32'h0);
    tick();
    chk("wrap_pc_next", pc, 32'h0);
    tick();
    chk("pre_rst_pc", pc, 32'h4);

    // Async reset mid-request
    imem_ready = 1'b0;
    tick();
    chk("pre_rst_req", imem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   imem_req,    1'b0);
    chk("arst_pc",    pc,          32'h0);
    chk("arst_flush", flush,       1'b0);
    imem_ready = 1'b1;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_idle_req", imem_req, 1'b0);
    tick();
    chk("rel_req",  imem_req,  1'b1);
    chk("rel_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
